// File: rtl/edge_pkg.sv
// Shared constants and types for the edge-label processing blocks.
// Image geometry, label encodings and the pixel address type.
package edge_pkg;

    localparam int IMG_WIDTH   = 640;
    localparam int IMG_HEIGHT  = 480;
    localparam int EDGE_DEPTH  = IMG_WIDTH * IMG_HEIGHT;
    localparam int EDGE_ADDR_W = 19;

    localparam logic [2:0] LBL_EMPTY     = 3'b000;
    localparam logic [2:0] LBL_CLEARED   = 3'b001;
    localparam logic [2:0] LBL_CANDIDATE = 3'b011;
    localparam logic [2:0] LBL_TRACED    = 3'b111;

    typedef logic [EDGE_ADDR_W-1:0] pix_addr_t;

    function automatic pix_addr_t pix_addr(input int x, input int y);
        return pix_addr_t'(y * IMG_WIDTH + x);
    endfunction

endpackage

// File: rtl/edge_bram_arbiter_if.sv
// Requester-side bus of the edge-label BRAM arbiter (flattened per-requester slices).
// master = requester side, slave = arbiter side.
interface edge_bram_arbiter_if #(
    parameter int N_REQ  = 3,
    parameter int ADDR_W = 19,
    parameter int DATA_W = 3
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ-1:0]        we;
    logic [N_REQ*ADDR_W-1:0] addr;
    logic [N_REQ*DATA_W-1:0] wdata;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ-1:0]        rvalid;
    logic [DATA_W-1:0]       rdata;

    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/edge_arb_pick.sv
// Combinational winner selection for the edge BRAM arbiter.
// EDGE_ARB_RR_EN selects round-robin from ptr; otherwise lowest eligible index wins.
module edge_arb_pick #(
    parameter int N_REQ = 3,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] elig,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] win_idx,
    output logic             win_any
);

`ifdef EDGE_ARB_RR_EN
    always_comb begin
        int cand;
        cand    = 0;
        win_idx = '0;
        win_any = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= N_REQ) cand = cand - N_REQ;
            if (!win_any && elig[cand]) begin
                win_any = 1'b1;
                win_idx = IDX_W'(cand);
            end
        end
    end
`else
    logic ptr_unused;
    assign ptr_unused = ^ptr;

    always_comb begin
        win_idx = '0;
        win_any = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (elig[k]) begin
                win_any = 1'b1;
                win_idx = IDX_W'(k);
            end
        end
    end
`endif

endmodule

// File: rtl/edge_bram_arbiter.sv
// Single-port edge-label BRAM arbiter: one access per cycle, registered grants, read-return pipeline.
// Define EDGE_ARB_RR_EN for round-robin picking; default is fixed priority (index 0 highest).
module edge_bram_arbiter
    import edge_pkg::*;
#(
    parameter int N_REQ    = 3,
    parameter int ADDR_W   = 19,
    parameter int DATA_W   = 3,
    parameter int DEPTH    = EDGE_DEPTH,
    parameter int READ_LAT = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    edge_bram_arbiter_if.slave  bus,
    output logic [ADDR_W-1:0]   bram_addr,
    output logic                bram_we,
    output logic [DATA_W-1:0]   bram_din,
    input  logic [DATA_W-1:0]   bram_dout,
    output logic                oor_err
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int N_PAD = 1 << IDX_W;
    localparam int LAST  = READ_LAT - 1;
    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

    // Per-requester views padded to a power of two so any win_idx is a legal index.
    logic [ADDR_W-1:0] addr_arr  [N_PAD];
    logic [DATA_W-1:0] wdata_arr [N_PAD];
    logic              we_arr    [N_PAD];

    for (genvar gi = 0; gi < N_PAD; gi++) begin : g_unpack
        if (gi < N_REQ) begin : g_real
            assign addr_arr[gi]  = bus.addr[gi*ADDR_W +: ADDR_W];
            assign wdata_arr[gi] = bus.wdata[gi*DATA_W +: DATA_W];
            assign we_arr[gi]    = bus.we[gi];
        end else begin : g_pad
            assign addr_arr[gi]  = '0;
            assign wdata_arr[gi] = '0;
            assign we_arr[gi]    = 1'b0;
        end
    end

    logic [N_REQ-1:0]  gnt_reg, rvalid_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic [ADDR_W-1:0] bram_addr_reg;
    logic              bram_we_reg;
    logic [DATA_W-1:0] bram_din_reg;
    logic              oor_err_reg;

    logic [N_REQ-1:0]  elig, win_onehot, rv_onehot;
    logic [IDX_W-1:0]  win_idx, pick_ptr;
    logic              win_any;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_we, sel_oor;

    // A requester is masked during its own grant cycle so a held req is not granted twice.
    assign elig = bus.req & ~gnt_reg;

    edge_arb_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
        .elig    (elig),
        .ptr     (pick_ptr),
        .win_idx (win_idx),
        .win_any (win_any)
    );

`ifdef EDGE_ARB_RR_EN
    logic [IDX_W-1:0] rr_ptr_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_reg <= '0;
        end else if (win_any) begin
            rr_ptr_reg <= (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
        end
    end

    assign pick_ptr = rr_ptr_reg;
`else
    assign pick_ptr = '0;
`endif

    always_comb begin
        sel_addr   = addr_arr[win_idx];
        sel_wdata  = wdata_arr[win_idx];
        sel_we     = we_arr[win_idx];
        sel_oor    = ({1'b0, sel_addr} >= DEPTH_V);
        win_onehot = N_REQ'(win_any) << win_idx;
    end

    // Read-return pipeline: {valid, requester id, out-of-range} per granted read.
    logic [READ_LAT-1:0]            pipe_vld_reg, pipe_vld_next;
    logic [READ_LAT-1:0][IDX_W-1:0] pipe_id_reg,  pipe_id_next;
    logic [READ_LAT-1:0]            pipe_oor_reg, pipe_oor_next;

    for (genvar gi = 0; gi < READ_LAT; gi++) begin : g_pipe
        if (gi == 0) begin : g_head
            assign pipe_vld_next[gi] = win_any & ~sel_we;
            assign pipe_id_next[gi]  = win_idx;
            assign pipe_oor_next[gi] = sel_oor;
        end else begin : g_body
            assign pipe_vld_next[gi] = pipe_vld_reg[gi-1];
            assign pipe_id_next[gi]  = pipe_id_reg[gi-1];
            assign pipe_oor_next[gi] = pipe_oor_reg[gi-1];
        end
    end

    assign rv_onehot = N_REQ'(pipe_vld_reg[LAST]) << pipe_id_reg[LAST];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_reg       <= '0;
            rvalid_reg    <= '0;
            rdata_reg     <= '0;
            bram_addr_reg <= '0;
            bram_we_reg   <= 1'b0;
            bram_din_reg  <= '0;
            oor_err_reg   <= 1'b0;
            pipe_vld_reg  <= '0;
            pipe_id_reg   <= '0;
            pipe_oor_reg  <= '0;
        end else begin
            gnt_reg     <= win_onehot;
            bram_we_reg <= win_any & sel_we & ~sel_oor;
            if (win_any) begin
                bram_addr_reg <= sel_addr;
                bram_din_reg  <= sel_wdata;
            end
            if (win_any && sel_oor) oor_err_reg <= 1'b1;
            pipe_vld_reg <= pipe_vld_next;
            pipe_id_reg  <= pipe_id_next;
            pipe_oor_reg <= pipe_oor_next;
            rvalid_reg   <= rv_onehot;
            if (pipe_vld_reg[LAST]) rdata_reg <= pipe_oor_reg[LAST] ? '0 : bram_dout;
        end
    end

    assign bus.gnt    = gnt_reg;
    assign bus.rvalid = rvalid_reg;
    assign bus.rdata  = rdata_reg;
    assign bram_addr  = bram_addr_reg;
    assign bram_we    = bram_we_reg;
    assign bram_din   = bram_din_reg;
    assign oor_err    = oor_err_reg;

endmodule

// File: tb/tb_edge_bram_arbiter.sv
// Randomized bench for edge_bram_arbiter against a transaction-level reference model.
// Follows EDGE_ARB_RR_EN the same way as the design build.
module tb_edge_bram_arbiter;
    import edge_pkg::*;

    localparam int N   = 3;
    localparam int AW  = 19;
    localparam int DW  = 3;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    edge_bram_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    logic [AW-1:0] bram_addr;
    logic          bram_we;
    logic [DW-1:0] bram_din;
    logic [DW-1:0] bram_dout = '0;
    logic          oor_err;

    edge_bram_arbiter #(
        .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .DEPTH(EDGE_DEPTH), .READ_LAT(LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .bram_addr (bram_addr),
        .bram_we   (bram_we),
        .bram_din  (bram_din),
        .bram_dout (bram_dout),
        .oor_err   (oor_err)
    );

    // Environment BRAM: read-first, one-cycle dout after the address edge.
    logic [DW-1:0] bram_mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (bram_we) bram_mem[bram_addr] <= bram_din;
        bram_dout <= bram_mem[bram_addr];
    end

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model state: what the outputs should show in the coming cycle.
    logic [N-1:0]  m_gnt, m_rvalid;
    logic [AW-1:0] m_addr;
    logic          m_we, m_oor;
    logic [DW-1:0] m_din, m_rdata;
    int            m_ptr;
    logic [DW-1:0] ref_mem [int];

    typedef struct {
        int            due;
        int            id;
        logic [DW-1:0] data;
    } ret_t;
    ret_t pend[$];

    // Requester agents
    logic          act   [N];
    logic          a_we  [N];
    logic [AW-1:0] a_addr[N];
    logic [DW-1:0] a_wd  [N];

    function automatic logic [AW-1:0] pick_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r <= 5) return AW'($urandom_range(0, 7));
        if (r == 6) return AW'(500);
        if (r == 7) return AW'(1000);
        if (r == 8) return AW'(EDGE_DEPTH - 1);
        return AW'(EDGE_DEPTH + $urandom_range(0, 3));
    endfunction

    task automatic drive_agents();
        logic [N-1:0]    rq, w;
        logic [N*AW-1:0] av;
        logic [N*DW-1:0] dv;
        for (int i = 0; i < N; i++) begin
            rq[i] = act[i];
            w[i]  = a_we[i];
            av[i*AW +: AW] = a_addr[i];
            dv[i*DW +: DW] = a_wd[i];
        end
        bus.req   = rq;
        bus.we    = w;
        bus.addr  = av;
        bus.wdata = dv;
    endtask

    task automatic model_reset();
        m_gnt = '0; m_rvalid = '0; m_rdata = '0;
        m_addr = '0; m_we = 1'b0; m_din = '0; m_oor = 1'b0;
        m_ptr = 0;
        pend.delete();
    endtask

    // One clock edge of the arbiter, described by its rules rather than its registers.
    task automatic model_step();
        logic [N-1:0] elig;
        int w;
        logic oor;
        elig = bus.req & ~m_gnt;
        w = -1;
        for (int k = 0; k < N; k++) begin
            int i;
`ifdef EDGE_ARB_RR_EN
            i = (m_ptr + k) % N;
`else
            i = k;
`endif
            if (w < 0 && elig[i]) w = i;
        end
        if (w >= 0) begin
            oor    = (int'(a_addr[w]) >= EDGE_DEPTH);
            m_gnt  = N'(1) << w;
            m_addr = a_addr[w];
            m_din  = a_wd[w];
            m_we   = a_we[w] && !oor;
            if (oor) m_oor = 1'b1;
            if (a_we[w] && !oor) ref_mem[int'(a_addr[w])] = a_wd[w];
            if (!a_we[w]) pend.push_back('{cyc + 1 + LAT, w,
                oor ? LBL_EMPTY : (ref_mem.exists(int'(a_addr[w])) ? ref_mem[int'(a_addr[w])] : LBL_EMPTY)});
            m_ptr  = (w + 1) % N;
            $display("cycle %0d grant req%0d %s addr=%0d wdata=%0h", cyc, w, a_we[w] ? "WR" : "RD", a_addr[w], a_wd[w]);
        end else begin
            m_gnt = '0;
            m_we  = 1'b0;
        end
        m_rvalid = '0;
        if (pend.size() > 0 && pend[0].due == cyc + 1) begin
            m_rvalid = N'(1) << pend[0].id;
            m_rdata  = pend[0].data;
            pend.pop_front();
        end
    endtask

    task automatic check_outputs(input bit with_rdata);
        chk_val("gnt", 32'(bus.gnt), 32'(m_gnt));
        chk_val("rvalid", 32'(bus.rvalid), 32'(m_rvalid));
        if (with_rdata || m_rvalid != '0) chk_val("rdata", 32'(bus.rdata), 32'(m_rdata));
        chk_val("bram_addr", 32'(bram_addr), 32'(m_addr));
        chk_val("bram_we", 32'(bram_we), 32'(m_we));
        if (m_gnt != '0) chk_val("bram_din", 32'(bram_din), 32'(m_din));
        chk_val("oor_err", 32'(oor_err), 32'(m_oor));
        if (m_rvalid != '0) $display("cycle %0d return rvalid=%b rdata=%0h", cyc, bus.rvalid, bus.rdata);
    endtask

    // rate: percent chance an idle requester starts a new access; sat: all keep requesting
    task automatic run_cycle(input int rate, input bit sat);
        @(negedge clk);
        check_outputs(1'b0);
        for (int i = 0; i < N; i++) begin
            if (act[i] && m_gnt[i]) act[i] = 1'b0;
            if (!act[i] && (sat || $urandom_range(0, 99) < rate)) begin
                act[i]    = 1'b1;
                a_we[i]   = 1'($urandom_range(0, 1));
                a_addr[i] = pick_addr();
                a_wd[i]   = DW'($urandom);
            end
        end
        drive_agents();
        model_step();
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) act[i] = 1'b0;
        drive_agents();
        model_reset();
        #1;
        check_outputs(1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        model_step();
        cyc++;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            act[i] = 1'b0; a_we[i] = 1'b0; a_addr[i] = '0; a_wd[i] = '0;
        end
        drive_agents();
        for (int a = 0; a < 8; a++) begin
            bram_mem[a] = DW'($urandom);
            ref_mem[a]  = bram_mem[a];
        end
        bram_mem[500] = LBL_CLEARED;        ref_mem[500] = LBL_CLEARED;
        bram_mem[1000] = LBL_CANDIDATE;     ref_mem[1000] = LBL_CANDIDATE;
        bram_mem[EDGE_DEPTH-1] = LBL_TRACED; ref_mem[EDGE_DEPTH-1] = LBL_TRACED;

        do_reset();

        // Directed read of a preloaded label by the tracer.
        act[1] = 1'b1; a_we[1] = 1'b0; a_addr[1] = AW'(1000);
        repeat (5) run_cycle(0, 1'b0);

        // Random mixed traffic, then saturation to exercise the pick order.
        repeat (250) run_cycle(40, 1'b0);
        repeat (10) run_cycle(0, 1'b0);
        repeat (30) run_cycle(0, 1'b1);
        repeat (10) run_cycle(0, 1'b0);

        // Reset one cycle after a read grant: the in-flight read must vanish.
        act[1] = 1'b1; a_we[1] = 1'b0; a_addr[1] = AW'(1000);
        repeat (2) run_cycle(0, 1'b0);
        do_reset();
        repeat (4) run_cycle(0, 1'b0);

        act[1] = 1'b1; a_we[1] = 1'b0; a_addr[1] = AW'(1000);
        repeat (5) run_cycle(0, 1'b0);

        // Out-of-range write and read by the display port.
        act[2] = 1'b1; a_we[2] = 1'b1; a_addr[2] = AW'(EDGE_DEPTH); a_wd[2] = 3'b101;
        repeat (2) run_cycle(0, 1'b0);
        act[2] = 1'b1; a_we[2] = 1'b0; a_addr[2] = AW'(EDGE_DEPTH);
        repeat (6) run_cycle(0, 1'b0);

        repeat (200) run_cycle(70, 1'b0);
        repeat (10) run_cycle(0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
